// File: rtl/q65_response_checker.sv
// q65_response_checker
//   End-of-chain checker for the q65 stimulus sequencer. Each accepted tick
//   compares the DUT response with its golden value, folds the response into a
//   MISR signature and tracks the mismatch count and the first failing index.
//   When the sequence ends it reports a single pass/fail.
//
//   Optional build macro: Q65CHK_STOP_ON_FAIL_EN
//     defined   - the first mismatch ends the run on that edge; that sample is
//                 still counted and folded, and later samples are ignored
//     undefined - the run always continues to s_last
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   start           begin a run (honoured in IDLE or DONE)
//   s_valid         qualifies s_idx / s_resp / s_exp / s_last
//   s_idx           sequencer tick index of this sample
//   s_resp, s_exp   DUT response and golden expected value
//   s_last          final sample of the sequence
//   busy            run in progress
//   done            run finished, held until start or reset
//   pass            done with zero mismatches
//   err_count       saturating mismatch count
//   first_err_idx   s_idx of the first mismatch, all ones if none
//   signature       running MISR value
//   samples         samples accepted in this run
module q65_response_checker #(
  parameter int               DATA_W = 8,
  parameter int               SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = 16'h1021,
  parameter logic [SIG_W-1:0] SEED   = 16'hFFFF,
  parameter int               CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [31:0]       s_idx,
  input  logic [DATA_W-1:0] s_resp,
  input  logic [DATA_W-1:0] s_exp,
  input  logic              s_last,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [31:0]       first_err_idx,
  output logic [SIG_W-1:0]  signature,
  output logic [31:0]       samples
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_n;

  logic             accept;
  logic             mismatch;
  logic             start_go;
  logic             stop;
  logic [SIG_W-1:0] sig_next;

  assign accept   = (state == RUN) && s_valid;
  assign mismatch = (s_resp != s_exp);
  assign start_go = start && ((state == IDLE) || (state == DONE));

`ifdef Q65CHK_STOP_ON_FAIL_EN
  assign stop = accept && mismatch;
`else
  assign stop = 1'b0;
`endif

  // Shift left, conditionally fold in the polynomial on the outgoing bit,
  // then mix in the response zero-extended to the signature width.
  assign sig_next = ({signature[SIG_W-2:0], 1'b0} ^ (signature[SIG_W-1] ? POLY : '0))
                  ^ SIG_W'(s_resp);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if ((accept && s_last) || stop) state_n = DONE;
      DONE:    if (start) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count     <= '0;
      first_err_idx <= '1;
      signature     <= SEED;
      samples       <= '0;
    end else if (start_go) begin
      err_count     <= '0;
      first_err_idx <= '1;
      signature     <= SEED;
      samples       <= '0;
    end else if (accept) begin
      samples   <= samples + 32'd1;
      signature <= sig_next;
      if (mismatch) begin
        if (err_count != '1) err_count <= err_count + CNT_W'(1);
        if (first_err_idx == '1) first_err_idx <= s_idx;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

endmodule
